datapath_op_sequencer: RTL and testbench
========================================

// Module: datapath_op_sequencer
// PURPOSE
//  Hardware control sequencer for the CPU datapath: turns one accepted command into the timed
//  control-signal sequence (register load via MDR, ALU op via Y/Z, 64-bit writeback to HI/LO).
//  Sits between the control unit and CPU_Datapath, driving its Rin/Rout/Y/Z/MDR strobes.
//  Generalises the hand-written load/T-state bench sequence: parametrised register count,
//  widths and step stretch, with a start/ready handshake and error reporting.
// PARAMETERS
//  NUM_REGS     16  general registers driven (one-hot Rin/Rout vectors)
//  REG_IDX_W    4   register index width; must satisfy 2**REG_IDX_W >= NUM_REGS
//  DATA_W       32  width of the immediate driven onto Mdatain
//  ALU_SEL_W    5   ALU selection code width
//  STEP_CYCLES  1   clocks each control step is held (>=1)
// PORTS
//  clk           in   1          rising-edge clock
//  clr           in   1          synchronous active-high reset
//  start         in   1          command valid; accepted when start & ready at posedge clk
//  ready         out  1          sequencer idle, can accept
//  done          out  1          1-cycle pulse on final step of a command
//  err           out  1          1-cycle pulse: rejected command (bad mode / index)
//  cmd_mode      in   2          00 LOAD, 01 ALU, 10 WIDE, 11 reserved
//  cmd_ra        in   REG_IDX_W  source A index (ALU/WIDE)
//  cmd_rb        in   REG_IDX_W  source B index (ALU/WIDE)
//  cmd_rd        in   REG_IDX_W  destination index (LOAD/ALU)
//  cmd_alu_sel   in   ALU_SEL_W  ALU operation code
//  cmd_imm       in   DATA_W     LOAD immediate
//  Rin / Rout    out  NUM_REGS   one-hot register load / bus-drive strobes
//  Yin Zin ZLOin ZHIin HIin Loin MDRin MDRout Read ZLOout ZHIout ZLowSelect ZHighSelect  out 1
//  ALUSelection  out  ALU_SEL_W  registered copy of cmd_alu_sel while busy, else 0
//  Mdatain       out  DATA_W     registered cmd_imm while busy, else 0
// BEHAVIOUR
//  - All outputs registered; clr: every output 0, ready=1, state IDLE, step counter 0, at next edge.
//  - Accept: start&ready → latch cmd, ready=0, first step outputs valid the following cycle.
//  - Reject (no accept, ready stays 1, err=1 next cycle): cmd_mode=11, or any used index >= NUM_REGS.
//  - start while ready=0 ignored, no err. Each step lasts STEP_CYCLES clocks (counter 0..S-1).
//  - LOAD:  L1 Read,MDRin (Mdatain=imm) → L2 MDRout,Rin[rd], done.
//  - ALU:   A1 Rout[ra],Yin → A2 Rout[rb],Zin,ZLOin,ZLowSelect,ALUSelection → A3 ZLOout,Rin[rd], done.
//  - WIDE:  A1,A2 as ALU plus ZHIin,ZHighSelect in A2 → W3 ZLOout,Loin → W4 ZHIout,HIin, done.
//  - After final step: ready=1 next cycle; back-to-back start accepted that same cycle.
//  - Latency accept→done: LOAD 2S, ALU 3S, WIDE 4S cycles (S=STEP_CYCLES); done high last cycle only.
//  - Invariant: at most one bus driver (Rout bit, MDRout, ZLOout, ZHIout) high per cycle.
//  - ra==rb, rd==ra legal (distinct steps, no conflict). clr mid-command aborts, no done.
// TESTING
//  - clr=1 two cycles → all outputs 0, ready=1; release, idle outputs stay 0.
//  - LOAD rd=2 imm=0x0000000A, S=1 → c1 Read,MDRin,Mdatain=0x0A; c2 MDRout,Rin=0x0004,done; c3 ready.
//  - ALU ra=2 rb=3 rd=1 sel=5'b00101 → c1 Rout=0x0004,Yin; c2 Rout=0x0008,Zin,ALUSelection=00101;
//    c3 ZLOout,Rin=0x0002,done.
//  - WIDE ra=1 rb=2, S=3 → Loin window cycles 7-9, HIin 10-12, done only at cycle 12.
//  - cmd_mode=11, or NUM_REGS=8 with rd=9 → err pulse, no strobes, ready stays 1.
//  - clr at ALU step A2 → next cycle all 0, ready=1, no done; new LOAD then completes normally.

Source files
------------

// File: rtl/datapath_op_sequencer_if.sv
// Command handshake and datapath control-strobe bundle between the control unit
// (master) and the datapath op sequencer (slave).
interface datapath_op_sequencer_if #(
    parameter int NUM_REGS  = 16,
    parameter int REG_IDX_W = 4,
    parameter int DATA_W    = 32,
    parameter int ALU_SEL_W = 5
);
    logic                 start;
    logic                 ready;
    logic                 done;
    logic                 err;
    logic [1:0]           cmd_mode;
    logic [REG_IDX_W-1:0] cmd_ra;
    logic [REG_IDX_W-1:0] cmd_rb;
    logic [REG_IDX_W-1:0] cmd_rd;
    logic [ALU_SEL_W-1:0] cmd_alu_sel;
    logic [DATA_W-1:0]    cmd_imm;
    logic [NUM_REGS-1:0]  Rin;
    logic [NUM_REGS-1:0]  Rout;
    logic Yin, Zin, ZLOin, ZHIin, HIin, Loin, MDRin, MDRout, Read;
    logic ZLOout, ZHIout, ZLowSelect, ZHighSelect;
    logic [ALU_SEL_W-1:0] ALUSelection;
    logic [DATA_W-1:0]    Mdatain;

    modport master (
        output start, cmd_mode, cmd_ra, cmd_rb, cmd_rd, cmd_alu_sel, cmd_imm,
        input  ready, done, err, Rin, Rout, Yin, Zin, ZLOin, ZHIin, HIin, Loin,
               MDRin, MDRout, Read, ZLOout, ZHIout, ZLowSelect, ZHighSelect,
               ALUSelection, Mdatain
    );

    modport slave (
        input  start, cmd_mode, cmd_ra, cmd_rb, cmd_rd, cmd_alu_sel, cmd_imm,
        output ready, done, err, Rin, Rout, Yin, Zin, ZLOin, ZHIin, HIin, Loin,
               MDRin, MDRout, Read, ZLOout, ZHIout, ZLowSelect, ZHighSelect,
               ALUSelection, Mdatain
    );
endinterface

// File: rtl/datapath_op_sequencer.sv
// Turns one accepted LOAD / ALU / WIDE command into the timed Rin/Rout/Y/Z/MDR/HI/LO
// strobe sequence for CPU_Datapath; every step is held STEP_CYCLES clocks.
module datapath_op_sequencer #(
    parameter int NUM_REGS    = 16,
    parameter int REG_IDX_W   = 4,
    parameter int DATA_W      = 32,
    parameter int ALU_SEL_W   = 5,
    parameter int STEP_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   clr,
    datapath_op_sequencer_if.slave bus
);
    localparam int               CNT_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_LOAD = 2'b00, MODE_ALU = 2'b01, MODE_WIDE = 2'b10, MODE_RSVD = 2'b11
    } mode_e;

    typedef enum logic [2:0] {S_IDLE, S_L1, S_L2, S_A1, S_A2, S_A3, S_W3, S_W4} state_e;

    typedef struct packed {
        logic yin, zin, zlo_in, zhi_in, hi_in, lo_in, mdr_in, mdr_out, read;
        logic zlo_out, zhi_out, zlo_sel, zhi_sel;
    } strobe_t;

    typedef struct packed {
        mode_e                mode;
        logic [REG_IDX_W-1:0] ra;
        logic [REG_IDX_W-1:0] rb;
        logic [REG_IDX_W-1:0] rd;
        logic [ALU_SEL_W-1:0] alu_sel;
        logic [DATA_W-1:0]    imm;
    } cmd_t;

    typedef struct packed {
        logic                 ready;
        logic                 done;
        logic                 err;
        logic [NUM_REGS-1:0]  rin;
        logic [NUM_REGS-1:0]  rout;
        strobe_t              strobe;
        logic [ALU_SEL_W-1:0] alu_sel;
        logic [DATA_W-1:0]    mdata;
    } out_t;

    state_e           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    cmd_t             cmd_in, cmd_q, cmd_n;
    out_t             out_q, out_n;
    logic             cmd_bad, accept, reject;

    function automatic logic idx_bad(input logic [REG_IDX_W-1:0] idx);
        return int'(idx) >= NUM_REGS;
    endfunction

    function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_IDX_W-1:0] idx);
        return NUM_REGS'(1) << idx;
    endfunction

    // Command decode: only the indices a mode actually uses can reject it.
    always_comb begin
        cmd_in = '{mode: mode_e'(bus.cmd_mode), ra: bus.cmd_ra, rb: bus.cmd_rb,
                   rd: bus.cmd_rd, alu_sel: bus.cmd_alu_sel, imm: bus.cmd_imm};
        case (cmd_in.mode)
            MODE_LOAD: cmd_bad = idx_bad(cmd_in.rd);
            MODE_ALU:  cmd_bad = idx_bad(cmd_in.ra) || idx_bad(cmd_in.rb) || idx_bad(cmd_in.rd);
            MODE_WIDE: cmd_bad = idx_bad(cmd_in.ra) || idx_bad(cmd_in.rb);
            default:   cmd_bad = 1'b1;
        endcase
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        reject  = 1'b0;
        if (state == S_IDLE) begin
            if (bus.start && out_q.ready) begin
                if (cmd_bad) begin
                    reject = 1'b1;
                end else begin
                    accept  = 1'b1;
                    cnt_n   = '0;
                    state_n = (cmd_in.mode == MODE_LOAD) ? S_L1 : S_A1;
                end
            end
        end else if (cnt != CNT_LAST) begin
            cnt_n = cnt + CNT_W'(1);
        end else begin
            cnt_n = '0;
            case (state)
                S_L1:    state_n = S_L2;
                S_A1:    state_n = S_A2;
                S_A2:    state_n = (cmd_q.mode == MODE_WIDE) ? S_W3 : S_A3;
                S_W3:    state_n = S_W4;
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so the registered strobes line up with the step.
    always_comb begin
        cmd_n = accept ? cmd_in : cmd_q;
        out_n = '0;
        case (state_n)
            S_L1: begin
                out_n.strobe.read   = 1'b1;
                out_n.strobe.mdr_in = 1'b1;
            end
            S_L2: begin
                out_n.strobe.mdr_out = 1'b1;
                out_n.rin            = onehot(cmd_n.rd);
            end
            S_A1: begin
                out_n.rout       = onehot(cmd_n.ra);
                out_n.strobe.yin = 1'b1;
            end
            S_A2: begin
                out_n.rout           = onehot(cmd_n.rb);
                out_n.strobe.zin     = 1'b1;
                out_n.strobe.zlo_in  = 1'b1;
                out_n.strobe.zlo_sel = 1'b1;
                out_n.strobe.zhi_in  = (cmd_n.mode == MODE_WIDE);
                out_n.strobe.zhi_sel = (cmd_n.mode == MODE_WIDE);
            end
            S_A3: begin
                out_n.strobe.zlo_out = 1'b1;
                out_n.rin            = onehot(cmd_n.rd);
            end
            S_W3: begin
                out_n.strobe.zlo_out = 1'b1;
                out_n.strobe.lo_in   = 1'b1;
            end
            S_W4: begin
                out_n.strobe.zhi_out = 1'b1;
                out_n.strobe.hi_in   = 1'b1;
            end
            default: ;
        endcase
        out_n.ready   = (state_n == S_IDLE);
        out_n.done    = (state_n inside {S_L2, S_A3, S_W4}) && (cnt_n == CNT_LAST);
        out_n.err     = reject;
        out_n.alu_sel = (state_n != S_IDLE) ? cmd_n.alu_sel : '0;
        out_n.mdata   = (state_n != S_IDLE) ? cmd_n.imm : '0;
    end

    // NOTE: state and outputs update with non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= S_IDLE;
            cnt         <= '0;
            out_q       <= '0;
            out_q.ready <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            out_q <= out_n;
        end
    end

    // NOTE: the command latch is pure data qualified by state, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) cmd_q <= cmd_in;
    end

    assign bus.ready        = out_q.ready;
    assign bus.done         = out_q.done;
    assign bus.err          = out_q.err;
    assign bus.Rin          = out_q.rin;
    assign bus.Rout         = out_q.rout;
    assign bus.Yin          = out_q.strobe.yin;
    assign bus.Zin          = out_q.strobe.zin;
    assign bus.ZLOin        = out_q.strobe.zlo_in;
    assign bus.ZHIin        = out_q.strobe.zhi_in;
    assign bus.HIin         = out_q.strobe.hi_in;
    assign bus.Loin         = out_q.strobe.lo_in;
    assign bus.MDRin        = out_q.strobe.mdr_in;
    assign bus.MDRout       = out_q.strobe.mdr_out;
    assign bus.Read         = out_q.strobe.read;
    assign bus.ZLOout       = out_q.strobe.zlo_out;
    assign bus.ZHIout       = out_q.strobe.zhi_out;
    assign bus.ZLowSelect   = out_q.strobe.zlo_sel;
    assign bus.ZHighSelect  = out_q.strobe.zhi_sel;
    assign bus.ALUSelection = out_q.alu_sel;
    assign bus.Mdatain      = out_q.mdata;
endmodule

// File: tb/tb_datapath_op_sequencer.sv
// Directed bench for datapath_op_sequencer: default instance (S=1), a stretched-step
// instance (S=3) and an 8-register instance for index rejection.
module tb_datapath_op_sequencer;
    logic clk = 1'b0;
    logic clr = 1'b1;
    int   tests = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    datapath_op_sequencer_if #(.NUM_REGS(16), .REG_IDX_W(4), .DATA_W(32), .ALU_SEL_W(5)) if0 ();
    datapath_op_sequencer_if #(.NUM_REGS(16), .REG_IDX_W(4), .DATA_W(32), .ALU_SEL_W(5)) if3 ();
    datapath_op_sequencer_if #(.NUM_REGS(8),  .REG_IDX_W(4), .DATA_W(32), .ALU_SEL_W(5)) if8 ();

    datapath_op_sequencer #(.NUM_REGS(16), .REG_IDX_W(4), .DATA_W(32), .ALU_SEL_W(5), .STEP_CYCLES(1))
        u0 (.clk(clk), .clr(clr), .bus(if0));
    datapath_op_sequencer #(.NUM_REGS(16), .REG_IDX_W(4), .DATA_W(32), .ALU_SEL_W(5), .STEP_CYCLES(3))
        u3 (.clk(clk), .clr(clr), .bus(if3));
    datapath_op_sequencer #(.NUM_REGS(8), .REG_IDX_W(4), .DATA_W(32), .ALU_SEL_W(5), .STEP_CYCLES(1))
        u8 (.clk(clk), .clr(clr), .bus(if8));

    // Strobe word bit positions: {Yin,Zin,ZLOin,ZHIin,HIin,Loin,MDRin,MDRout,Read,ZLOout,ZHIout,ZLowSelect,ZHighSelect}
    localparam logic [63:0] M_YIN = 64'h1000, M_ZIN = 64'h0800, M_ZLOIN = 64'h0400, M_ZHIIN = 64'h0200;
    localparam logic [63:0] M_HIIN = 64'h0100, M_LOIN = 64'h0080, M_MDRIN = 64'h0040, M_MDROUT = 64'h0020;
    localparam logic [63:0] M_READ = 64'h0010, M_ZLOOUT = 64'h0008, M_ZHIOUT = 64'h0004;
    localparam logic [63:0] M_ZLOSEL = 64'h0002, M_ZHISEL = 64'h0001;
    // Flag word is {ready, done, err}
    localparam logic [63:0] F_IDLE = 64'b100, F_BUSY = 64'b000, F_DONE = 64'b010, F_ERR = 64'b101;

    function automatic logic [12:0] str0();
        return {if0.Yin, if0.Zin, if0.ZLOin, if0.ZHIin, if0.HIin, if0.Loin, if0.MDRin, if0.MDRout,
                if0.Read, if0.ZLOout, if0.ZHIout, if0.ZLowSelect, if0.ZHighSelect};
    endfunction
    function automatic logic [12:0] str3();
        return {if3.Yin, if3.Zin, if3.ZLOin, if3.ZHIin, if3.HIin, if3.Loin, if3.MDRin, if3.MDRout,
                if3.Read, if3.ZLOout, if3.ZHIout, if3.ZLowSelect, if3.ZHighSelect};
    endfunction
    function automatic logic [12:0] str8();
        return {if8.Yin, if8.Zin, if8.ZLOin, if8.ZHIin, if8.HIin, if8.Loin, if8.MDRin, if8.MDRout,
                if8.Read, if8.ZLOout, if8.ZHIout, if8.ZLowSelect, if8.ZHighSelect};
    endfunction
    function automatic logic [2:0] flg0(); return {if0.ready, if0.done, if0.err}; endfunction
    function automatic logic [2:0] flg3(); return {if3.ready, if3.done, if3.err}; endfunction
    function automatic logic [2:0] flg8(); return {if8.ready, if8.done, if8.err}; endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd0(input logic [1:0] mode, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [3:0] rd, input logic [4:0] sel, input logic [31:0] imm);
        if0.cmd_mode = mode; if0.cmd_ra = ra; if0.cmd_rb = rb; if0.cmd_rd = rd;
        if0.cmd_alu_sel = sel; if0.cmd_imm = imm; if0.start = 1'b1;
    endtask

    task automatic cmd8(input logic [1:0] mode, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [3:0] rd, input logic [31:0] imm);
        if8.cmd_mode = mode; if8.cmd_ra = ra; if8.cmd_rb = rb; if8.cmd_rd = rd;
        if8.cmd_alu_sel = 5'd0; if8.cmd_imm = imm; if8.start = 1'b1;
    endtask

    logic [63:0] exp_str, exp_rout;

    initial begin
        if0.start = 1'b0; if3.start = 1'b0; if8.start = 1'b0;
        cmd0(2'b00, 4'd0, 4'd0, 4'd0, 5'd0, 32'd0); if0.start = 1'b0;
        cmd8(2'b00, 4'd0, 4'd0, 4'd0, 32'd0); if8.start = 1'b0;
        if3.cmd_mode = 2'b00; if3.cmd_ra = 4'd0; if3.cmd_rb = 4'd0; if3.cmd_rd = 4'd0;
        if3.cmd_alu_sel = 5'd0; if3.cmd_imm = 32'd0;

        // Reset held two cycles
        tick(); tick();
        check("rst_flags",  64'(flg0()), F_IDLE);
        check("rst_str",    64'(str0()), 64'h0);
        check("rst_rin",    64'(if0.Rin), 64'h0);
        check("rst_rout",   64'(if0.Rout), 64'h0);
        check("rst_alusel", 64'(if0.ALUSelection), 64'h0);
        check("rst_mdata",  64'(if0.Mdatain), 64'h0);
        check("rst3_flags", 64'(flg3()), F_IDLE);
        check("rst3_str",   64'(str3()), 64'h0);
        check("rst8_flags", 64'(flg8()), F_IDLE);
        check("rst8_str",   64'(str8()), 64'h0);
        clr = 1'b0;
        tick();
        check("idle_flags", 64'(flg0()), F_IDLE);
        check("idle_str",   64'(str0()), 64'h0);

        // LOAD rd=2 imm=0x0A
        cmd0(2'b00, 4'd0, 4'd0, 4'd2, 5'd0, 32'h0000_000A);
        tick(); if0.start = 1'b0;
        check("load_c1_str",   64'(str0()), M_READ | M_MDRIN);
        check("load_c1_mdata", 64'(if0.Mdatain), 64'h0A);
        check("load_c1_flags", 64'(flg0()), F_BUSY);
        tick();
        check("load_c2_str",   64'(str0()), M_MDROUT);
        check("load_c2_rin",   64'(if0.Rin), 64'h0004);
        check("load_c2_rout",  64'(if0.Rout), 64'h0);
        check("load_c2_flags", 64'(flg0()), F_DONE);
        tick();
        check("load_c3_flags", 64'(flg0()), F_IDLE);
        check("load_c3_str",   64'(str0()), 64'h0);
        check("load_c3_rin",   64'(if0.Rin), 64'h0);
        check("load_c3_mdata", 64'(if0.Mdatain), 64'h0);

        // ALU ra=2 rb=3 rd=1 sel=00101; a reserved-mode start while busy must be ignored
        cmd0(2'b01, 4'd2, 4'd3, 4'd1, 5'b00101, 32'd0);
        tick();
        check("alu_c1_str",   64'(str0()), M_YIN);
        check("alu_c1_rout",  64'(if0.Rout), 64'h0004);
        check("alu_c1_sel",   64'(if0.ALUSelection), 64'h05);
        check("alu_c1_flags", 64'(flg0()), F_BUSY);
        cmd0(2'b11, 4'd0, 4'd0, 4'd0, 5'd0, 32'd0);
        tick(); if0.start = 1'b0;
        check("alu_c2_str",   64'(str0()), M_ZIN | M_ZLOIN | M_ZLOSEL);
        check("alu_c2_rout",  64'(if0.Rout), 64'h0008);
        check("alu_c2_sel",   64'(if0.ALUSelection), 64'h05);
        check("alu_c2_flags", 64'(flg0()), F_BUSY);
        tick();
        check("alu_c3_str",   64'(str0()), M_ZLOOUT);
        check("alu_c3_rin",   64'(if0.Rin), 64'h0002);
        check("alu_c3_rout",  64'(if0.Rout), 64'h0);
        check("alu_c3_flags", 64'(flg0()), F_DONE);

        // Start raised during the final step: ignored there, accepted once ready returns
        cmd0(2'b00, 4'd0, 4'd0, 4'd15, 5'd0, 32'hDEAD_BEEF);
        tick();
        check("b2b_c4_flags", 64'(flg0()), F_IDLE);
        tick(); if0.start = 1'b0;
        check("b2b_c1_str",   64'(str0()), M_READ | M_MDRIN);
        check("b2b_c1_mdata", 64'(if0.Mdatain), 64'hDEAD_BEEF);
        tick();
        check("b2b_c2_rin",   64'(if0.Rin), 64'h8000);
        check("b2b_c2_flags", 64'(flg0()), F_DONE);
        tick();
        check("b2b_c3_flags", 64'(flg0()), F_IDLE);

        // ALU with ra==rb==rd at the top index
        cmd0(2'b01, 4'd15, 4'd15, 4'd15, 5'd3, 32'd0);
        tick(); if0.start = 1'b0;
        check("same_c1_rout", 64'(if0.Rout), 64'h8000);
        tick();
        check("same_c2_rout", 64'(if0.Rout), 64'h8000);
        tick();
        check("same_c3_rin",  64'(if0.Rin), 64'h8000);
        check("same_c3_flags", 64'(flg0()), F_DONE);
        tick();

        // Reserved mode rejected
        cmd0(2'b11, 4'd0, 4'd0, 4'd0, 5'd0, 32'd0);
        tick(); if0.start = 1'b0;
        check("rsvd_flags", 64'(flg0()), F_ERR);
        check("rsvd_str",   64'(str0()), 64'h0);
        check("rsvd_rin",   64'(if0.Rin), 64'h0);
        tick();
        check("rsvd_after_flags", 64'(flg0()), F_IDLE);

        // NUM_REGS=8: out-of-range indices rejected, rd=7 accepted
        cmd8(2'b00, 4'd0, 4'd0, 4'd9, 32'h55);
        tick(); if8.start = 1'b0;
        check("r8_rd9_flags", 64'(flg8()), F_ERR);
        check("r8_rd9_str",   64'(str8()), 64'h0);
        check("r8_rd9_rin",   64'(if8.Rin), 64'h0);
        check("r8_rd9_sel",   64'(if8.ALUSelection), 64'h0);
        tick();
        check("r8_after_flags", 64'(flg8()), F_IDLE);
        cmd8(2'b01, 4'd8, 4'd0, 4'd0, 32'h0);
        tick(); if8.start = 1'b0;
        check("r8_ra8_flags", 64'(flg8()), F_ERR);
        check("r8_ra8_rout",  64'(if8.Rout), 64'h0);
        tick();
        cmd8(2'b00, 4'd0, 4'd0, 4'd7, 32'h77);
        tick(); if8.start = 1'b0;
        check("r8_rd7_c1_str",   64'(str8()), M_READ | M_MDRIN);
        check("r8_rd7_c1_mdata", 64'(if8.Mdatain), 64'h77);
        tick();
        check("r8_rd7_c2_rin",   64'(if8.Rin), 64'h80);
        check("r8_rd7_c2_flags", 64'(flg8()), F_DONE);

        // WIDE ra=1 rb=2 with S=3: A1 1-3, A2 4-6, W3 7-9, W4 10-12, ready at 13
        if3.cmd_mode = 2'b10; if3.cmd_ra = 4'd1; if3.cmd_rb = 4'd2; if3.cmd_rd = 4'd0;
        if3.cmd_alu_sel = 5'h1F; if3.cmd_imm = 32'd0; if3.start = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            tick();
            if3.start = 1'b0;
            if (c <= 3) begin
                exp_str = M_YIN; exp_rout = 64'h0002;
            end else if (c <= 6) begin
                exp_str = M_ZIN | M_ZLOIN | M_ZHIIN | M_ZLOSEL | M_ZHISEL; exp_rout = 64'h0004;
            end else if (c <= 9) begin
                exp_str = M_ZLOOUT | M_LOIN; exp_rout = 64'h0;
            end else if (c <= 12) begin
                exp_str = M_ZHIOUT | M_HIIN; exp_rout = 64'h0;
            end else begin
                exp_str = 64'h0; exp_rout = 64'h0;
            end
            check($sformatf("wide_c%0d_str", c),   64'(str3()), exp_str);
            check($sformatf("wide_c%0d_rout", c),  64'(if3.Rout), exp_rout);
            check($sformatf("wide_c%0d_flags", c), 64'(flg3()), {61'd0, c == 13, c == 12, 1'b0});
            check($sformatf("wide_c%0d_sel", c),   64'(if3.ALUSelection), (c == 13) ? 64'h0 : 64'h1F);
        end
        check("wide_rin",   64'(if3.Rin), 64'h0);
        check("wide_mdata", 64'(if3.Mdatain), 64'h0);

        // clr during ALU step A2 aborts without done; a following LOAD runs normally
        cmd0(2'b01, 4'd2, 4'd3, 4'd1, 5'b00101, 32'd0);
        tick(); if0.start = 1'b0;
        tick();
        check("abort_a2_rout", 64'(if0.Rout), 64'h0008);
        clr = 1'b1;
        tick();
        check("abort_flags", 64'(flg0()), F_IDLE);
        check("abort_str",   64'(str0()), 64'h0);
        check("abort_rout",  64'(if0.Rout), 64'h0);
        check("abort_sel",   64'(if0.ALUSelection), 64'h0);
        clr = 1'b0;
        tick();
        check("abort_post_flags", 64'(flg0()), F_IDLE);
        check("abort_post_rin",   64'(if0.Rin), 64'h0);
        cmd0(2'b00, 4'd0, 4'd0, 4'd5, 5'd0, 32'h0000_0055);
        tick(); if0.start = 1'b0;
        check("relo_c1_str",   64'(str0()), M_READ | M_MDRIN);
        check("relo_c1_mdata", 64'(if0.Mdatain), 64'h55);
        tick();
        check("relo_c2_rin",   64'(if0.Rin), 64'h0020);
        check("relo_c2_flags", 64'(flg0()), F_DONE);
        tick();
        check("relo_c3_flags", 64'(flg0()), F_IDLE);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
